// File: rtl/ram2_dot_engine_if.sv
// RAM read bus and result stream between the dot engine and its neighbours.
// The master side is the engine; the slave side is the RAM and result consumer.
interface ram2_dot_engine_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int ROW_WIDTH  = 128
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic                  ram_oe;
  logic [ROW_WIDTH-1:0]  ram_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_idx;
  logic [15:0]           out_pred;
  logic [15:0]           out_err;

  modport master (
    output ram_addr, ram_we, ram_oe,
    input  ram_rdata,
    output out_valid, out_idx, out_pred, out_err,
    input  out_ready
  );

  modport slave (
    input  ram_addr, ram_we, ram_oe,
    output ram_rdata,
    input  out_valid, out_idx, out_pred, out_err,
    output out_ready
  );
endinterface

// File: rtl/ram2_dot_engine.sv
// Dot-product sequencer: reads the weight row, then each data row, and streams
// out the Q8.8 prediction (w.x + b) and error (pred - y) per data point.
module ram2_dot_engine #(
  parameter int ADDR_WIDTH   = 3,
  parameter int MAX_FEATURES = 7,
  parameter int ROW_WIDTH    = 16*(MAX_FEATURES+1),
  parameter int DEPTH        = 7,
  parameter int FEAT_BITS    = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_points,
  input  logic [FEAT_BITS-1:0]  num_features,
  output logic                  busy,
  output logic                  done,
  ram2_dot_engine_if.master     bus
);

  localparam logic [ADDR_WIDTH-1:0] MAX_PTS = ADDR_WIDTH'(DEPTH-1);
  localparam logic [FEAT_BITS-1:0]  MAX_NF  = FEAT_BITS'(MAX_FEATURES);

  typedef enum logic [3:0] {
    S_IDLE, S_W_REQ, S_W_WAIT, S_W_CAP,
    S_R_REQ, S_R_WAIT, S_R_CAP, S_MAC,
    S_FIN, S_OUT, S_DONE
  } state_e;

  typedef logic [MAX_FEATURES:0][15:0] row_t;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   np_q, np_d;
  logic [FEAT_BITS-1:0]    nf_q, nf_d;
  row_t                    w_q, w_d;
  row_t                    r_q, r_d;
  logic signed [31:0]      acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [FEAT_BITS-1:0]    k_q, k_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    oe_q, oe_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic [15:0]             pred_q, pred_d;
  logic [15:0]             err_q, err_d;

  logic [ROW_WIDTH-1:0]    rdata;
  logic signed [15:0]      w_k, x_k, b_s, y_s;
  logic signed [31:0]      prod, acc_mac;
  logic [15:0]             pred_sat;
  logic [16:0]             diff;

  // Clamp a 32-bit accumulator into signed 16-bit range.
  function automatic logic [15:0] sat32(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'h7FFF;
    else if (v < -32'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  // Clamp a 17-bit two's-complement difference into signed 16-bit range.
  function automatic logic [15:0] sat17(input logic [16:0] v);
    if (v[16] != v[15]) return v[16] ? 16'h8000 : 16'h7FFF;
    else                return v[15:0];
  endfunction

  assign rdata = bus.ram_rdata;

  // Datapath: current MAC term, bias/target slots and final saturation.
  assign w_k      = w_q[k_q];
  assign x_k      = r_q[k_q];
  assign b_s      = w_q[MAX_FEATURES];
  assign y_s      = r_q[MAX_FEATURES];
  assign prod     = 32'(w_k) * 32'(x_k);
  assign acc_mac  = acc_q + (prod >>> 8);
  assign pred_sat = sat32(acc_q);
  assign diff     = {pred_sat[15], pred_sat} - {y_s[15], y_s};

  // Next-state and next-output logic for the pass sequencer.
  always_comb begin
    state_d = state_q;
    np_d    = np_q;
    nf_d    = nf_q;
    w_d     = w_q;
    r_d     = r_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    k_d     = k_q;
    addr_d  = addr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = done_q;
    valid_d = valid_q;
    pred_d  = pred_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          np_d    = (num_points > MAX_PTS) ? MAX_PTS : num_points;
          nf_d    = (num_features > MAX_NF) ? MAX_NF : num_features;
          addr_d  = '0;
          oe_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = S_W_REQ;
        end
      end
      S_W_REQ:  state_d = S_W_WAIT;
      S_W_WAIT: state_d = S_W_CAP;
      S_W_CAP: begin
        w_d = rdata;
        if (np_q == '0) begin
          oe_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = ADDR_WIDTH'(1);
          addr_d  = ADDR_WIDTH'(1);
          state_d = S_R_REQ;
        end
      end
      S_R_REQ:  state_d = S_R_WAIT;
      S_R_WAIT: state_d = S_R_CAP;
      S_R_CAP: begin
        r_d     = rdata;
        acc_d   = {{16{b_s[15]}}, b_s};
        k_d     = '0;
        state_d = (nf_q != '0) ? S_MAC : S_FIN;
      end
      S_MAC: begin
        acc_d = acc_mac;
        k_d   = k_q + FEAT_BITS'(1);
        if (k_d == nf_q) state_d = S_FIN;
      end
      S_FIN: begin
        pred_d  = pred_sat;
        err_d   = sat17(diff);
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        // Results stay frozen in their registers until the consumer takes them.
        if (bus.out_ready) begin
          valid_d = 1'b0;
          if (idx_q == np_q) begin
            oe_d    = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            addr_d  = idx_q + ADDR_WIDTH'(1);
            state_d = S_R_REQ;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any pass in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      np_q    <= '0;
      nf_q    <= '0;
      w_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      pred_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      np_q    <= np_d;
      nf_q    <= nf_d;
      w_q     <= w_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      pred_q  <= pred_d;
      err_q   <= err_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_we    = 1'b0;
  assign bus.ram_oe    = oe_q;
  assign bus.out_valid = valid_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_pred  = pred_q;
  assign bus.out_err   = err_q;

endmodule

// File: doc/ram2_dot_engine.md
Name: ram2_dot_engine

Overview:
- Sequencer and datapath directly downstream of the weight/data-point RAM.
- Reads the weight row (address 0), then each data-point row (addresses 1..num_points).
- For each point, computes the fixed-point linear prediction and error, and streams them out over a valid/ready handshake.
- Feeds the gradient-update stage.

Parameters:
ADDR_WIDTH, 3, RAM address width
MAX_FEATURES, 7, feature slots per row
ROW_WIDTH, 16*(MAX_FEATURES+1), RAM row width
DEPTH, 7, RAM rows (row 0 = weights)
FEAT_BITS, 3, width of num_features

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
start  in  1  begin a pass; sampled in IDLE only
num_points  in  ADDR_WIDTH  data points to process
num_features  in  FEAT_BITS  active features (0..MAX_FEATURES)
ram_addr  out  ADDR_WIDTH  RAM address
ram_we  out  1  RAM write enable; tied 0
ram_oe  out  1  RAM output enable; 1 except in IDLE/DONE
ram_rdata  in  ROW_WIDTH  RAM data bus (read side)
busy  out  1  high from start acceptance until DONE exits
done  out  1  one-cycle pulse at end of pass
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_idx  out  ADDR_WIDTH  RAM address of the point (1..num_points)
out_pred  out  16  prediction, signed Q8.8
out_err  out  16  pred - y, signed Q8.8

Behaviour:
- Row layout:
  - slot k = bits [16k+15:16k].
  - Slots 0..MAX_FEATURES-1 hold x_k (data rows) or w_k (weight row).
  - Slot MAX_FEATURES holds y (data rows) or bias b (weight row).
- Values are signed Q8.8.
- Reset (sync): state=IDLE. All outputs 0 except ram_we=0; ram_oe=0. The weight register, row register, accumulator, idx and k are cleared. RST mid-pass aborts immediately; no done pulse.
- Latch rules: num_points and num_features are latched at start.
  - num_points > DEPTH-1 clamps to DEPTH-1.
  - num_features > MAX_FEATURES clamps to MAX_FEATURES.
- FSM (one transition per CLK):
  - IDLE: start=1 → W_REQ.
  - W_REQ: ram_addr=0 → W_WAIT → W_CAP. On exit, the weight register captures ram_rdata.
  - If latched num_points=0: W_CAP → DONE. Otherwise idx=1 → R_REQ.
  - R_REQ: ram_addr=idx → R_WAIT → R_CAP. On exit, the row register captures ram_rdata; acc=sign-extend(b) to 32 bits; k=0.
  - R_CAP → MAC if num_features>0, else FIN.
  - MAC: acc += (w_k*x_k)>>>8, using a 32-bit signed product with arithmetic shift; k++. Leaves to FIN after num_features cycles.
  - FIN: out_pred = sat16(acc); out_err = sat16(sat16(acc) - y), using a 17-bit difference. → OUT.
  - OUT: out_valid=1. out_idx/out_pred/out_err are held stable while out_ready=0.
  - On out_valid & out_ready: if idx==num_points → DONE, else idx++ → R_REQ. out_valid drops the cycle after the handshake.
  - DONE: done=1 for one cycle, busy=0 next → IDLE.
- Saturation: results saturate to 0x7FFF / 0x8000. The accumulator itself does not wrap within 7 terms.
- Latency: start accepted at edge t → out_valid first high after edge t+7+num_features.
- Per-point period with out_ready tied 1: 5+num_features cycles.
- start while busy is ignored. ram_addr is held between requests. ram_we is never asserted.

Test Plan:
- Basic point: w0=0x0100, w1=0x0200, b=0x0080; x0=0x0300, x1=0x0100, y=0x0500; num_features=2, num_points=1 → out_pred=0x0580, out_err=0x0080, out_idx=1, out_valid after edge t+9, done pulse follows.
- Saturation: w0=0x7F00, x0=0x0400, b=0, num_features=1 → out_pred=0x7FFF. Negative case: w0=0x8100, x0=0x0400 → out_pred=0x8000.
- Back-pressure: 3 points with out_ready low for 5 cycles on point 2 → outputs stable throughout; idx sequence 1,2,3; exactly 3 handshakes; one done pulse.
- num_points=0 → only address 0 read, no out_valid, done pulses 4 cycles after start. num_features=0 → out_pred=b for every point.
- Clamp/ignore: num_points=7 → only points 1..6 emitted. start pulsed while busy → no restart, idx continues.
- Reset mid-MAC → next cycle state IDLE, busy=0, out_valid=0, done never pulses. A new start then gives correct results.
